// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
// Also used by the optional UART_TX_ARB_LOCK_EN build.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    localparam int NUM_REQ_DFLT = 4;
    localparam int GNT_W        = $clog2(NUM_REQ_DFLT);

    // Width of a counter that must hold 0 .. max_count-1.
    function automatic int cnt_width(input int max_count);
        return (max_count <= 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/sender signal bundle for uart_tx_arbiter.
// UART_TX_ARB_LOCK_EN adds the per-requester req_lock input.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int GNT_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   done;
    logic                 tx_status;
    logic                 tx_en;
    logic [7:0]           tx_data;
    logic                 busy;
    logic [GNT_W-1:0]     grant_id;
    logic                 timeout_err;
    logic                 err_clr;

`ifdef UART_TX_ARB_LOCK_EN
    logic [NUM_REQ-1:0]   req_lock;

    modport master (
        output req, req_data, tx_status, err_clr, req_lock,
        input  ack, done, tx_en, tx_data, busy, grant_id, timeout_err
    );
    modport slave (
        input  req, req_data, tx_status, err_clr, req_lock,
        output ack, done, tx_en, tx_data, busy, grant_id, timeout_err
    );
`else
    modport master (
        output req, req_data, tx_status, err_clr,
        input  ack, done, tx_en, tx_data, busy, grant_id, timeout_err
    );
    modport slave (
        input  req, req_data, tx_status, err_clr,
        output ack, done, tx_en, tx_data, busy, grant_id, timeout_err
    );
`endif

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after last_id,
// wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_id,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       valid
);
    localparam int GW = $clog2(NUM_REQ);

    logic [GW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = GW'((int'(last_id) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART sender among NUM_REQ byte requesters.
// UART_TX_ARB_LOCK_EN keeps a locked owner granted across a multi-byte packet.
//
// state     | meaning
// IDLE      | waiting for a request while the synced sender status is idle
// LOAD      | byte latched, tx_en held high for TX_EN_CYCLES
// WAIT_BUSY | waiting for the sender to go busy, bounded by BUSY_TIMEOUT
// WAIT_DONE | sender busy, waiting for it to return to idle
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = NUM_REQ_DFLT,
    parameter int TX_EN_CYCLES = 4,
    parameter int BUSY_TIMEOUT = 1024,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = cnt_width((TX_EN_CYCLES > BUSY_TIMEOUT) ? TX_EN_CYCLES : BUSY_TIMEOUT);

    arb_state_e           state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [GW-1:0]        grant_id_q, grant_id_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_en_q, tx_en_d;
    logic                 busy_q, busy_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 to_set;
    logic                 st;
    logic [NUM_REQ-1:0]   req_eff;
    logic [GW-1:0]        winner;
    logic                 win_vld;

    assign st     = sync_q[SYNC_STAGES-1];
    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.tx_status};

`ifdef UART_TX_ARB_LOCK_EN
    logic lock_q, lock_d;
    // While locked, only the owner may win the next grant.
    assign req_eff = lock_q ? (bus.req & (NUM_REQ'(1) << grant_id_q)) : bus.req;
`else
    assign req_eff = bus.req;
`endif

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (req_eff),
        .last_id (grant_id_q),
        .winner  (winner),
        .valid   (win_vld)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_id_d = grant_id_q;
        tx_data_d  = tx_data_q;
        tx_en_d    = tx_en_q;
        ack_d      = '0;
        done_d     = '0;
        to_set     = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
        lock_d     = lock_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld && st) begin
                    state_d        = LOAD;
                    grant_id_d     = winner;
                    tx_data_d      = bus.req_data[8*winner +: 8];
                    ack_d[winner]  = 1'b1;
                    tx_en_d        = 1'b1;
                    cnt_d          = CW'(TX_EN_CYCLES - 1);
                end
            end
            LOAD: begin
                if (cnt_q == '0) begin
                    tx_en_d = 1'b0;
                    state_d = WAIT_BUSY;
                    cnt_d   = CW'(BUSY_TIMEOUT - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_BUSY: begin
                if (!st) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                    to_set  = 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
                    lock_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_DONE: begin
                if (st) begin
                    state_d            = IDLE;
                    done_d[grant_id_q] = 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
                    lock_d             = bus.req_lock[grant_id_q];
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // A timeout in the same cycle as err_clr must leave the flag set.
        timeout_err_d = to_set ? 1'b1 : (bus.err_clr ? 1'b0 : timeout_err_q);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sync_q        <= '1;
            cnt_q         <= '0;
            grant_id_q    <= GW'(NUM_REQ - 1);
            tx_data_q     <= '0;
            tx_en_q       <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            ack_q         <= '0;
            done_q        <= '0;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            cnt_q         <= cnt_d;
            grant_id_q    <= grant_id_d;
            tx_data_q     <= tx_data_d;
            tx_en_q       <= tx_en_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            ack_q         <= ack_d;
            done_q        <= done_d;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q        <= lock_d;
`endif
        end
    end

    assign bus.ack         = ack_q;
    assign bus.done        = done_q;
    assign bus.tx_en       = tx_en_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.busy        = busy_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART sender model.
// The lock scenario runs only when UART_TX_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int N = NUM_REQ_DFLT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus();

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .TX_EN_CYCLES (4),
        .BUSY_TIMEOUT (1024),
        .SYNC_STAGES  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Sender model: goes busy 10 clks after tx_en rises, idle again 200 clks later.
    bit   snd_en = 1'b1;
    bit   ext_busy = 1'b0;
    logic st_m;
    logic tx_en_prev;
    int   snd_cnt;
    int   snd_phase;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            st_m       <= 1'b1;
            tx_en_prev <= 1'b0;
            snd_cnt    <= 0;
            snd_phase  <= 0;
        end else begin
            tx_en_prev <= bus.tx_en;
            case (snd_phase)
                0: if (bus.tx_en && !tx_en_prev && snd_en) begin
                       snd_phase <= 1;
                       snd_cnt   <= 1;
                   end
                1: if (snd_cnt == 10) begin
                       st_m      <= 1'b0;
                       snd_phase <= 2;
                       snd_cnt   <= 1;
                   end else snd_cnt <= snd_cnt + 1;
                default: if (snd_cnt == 200) begin
                       st_m      <= 1'b1;
                       snd_phase <= 0;
                   end else snd_cnt <= snd_cnt + 1;
            endcase
        end
    end

    assign bus.tx_status = ext_busy ? 1'b0 : st_m;

    // Pulse counters and protocol-violation counter observed at negedge.
    int ack_cnt[N];
    int done_cnt[N];
    int ack_total = 0;
    int done_total = 0;
    int rise_total = 0;
    int viol = 0;
    logic en_last = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (bus.ack[i])  begin ack_cnt[i]  <= ack_cnt[i] + 1;  ack_total  <= ack_total + 1;  end
                if (bus.done[i]) begin done_cnt[i] <= done_cnt[i] + 1; done_total <= done_total + 1; end
            end
            if ($countones(bus.ack) > 1 || $countones(bus.done) > 1 ||
                (|bus.ack && |bus.done) || (bus.tx_en && !bus.busy))
                viol <= viol + 1;
            if (bus.tx_en && !en_last) rise_total <= rise_total + 1;
            en_last <= bus.tx_en;
        end else begin
            en_last <= 1'b0;
        end
    end

    task automatic wait_ack(input int limit, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (|bus.ack) begin seen = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (|bus.done) begin seen = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.ack !== 4'b0000)  begin failures++; $display("FAIL reset_ack: got %b expected 0000", bus.ack); end
        checks++; if (bus.done !== 4'b0000) begin failures++; $display("FAIL reset_done: got %b expected 0000", bus.done); end
        checks++; if (bus.tx_en !== 1'b0)   begin failures++; $display("FAIL reset_tx_en: got %b expected 0", bus.tx_en); end
        checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
        checks++; if (bus.busy !== 1'b0)    begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.grant_id !== GNT_W'(N-1)) begin failures++; $display("FAIL reset_grant_id: got %0d expected %0d", bus.grant_id, N-1); end
        checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err: got %b expected 0", bus.timeout_err); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int a0, d0, ten;
        bit seen;
        a0 = ack_cnt[2]; d0 = done_cnt[2];
        bus.req_data[23:16] = 8'hA5;
        bus.req[2] = 1'b1;
        wait_ack(20, seen);
        checks++; if (!seen || bus.ack !== 4'b0100) begin failures++; $display("FAIL single_ack: got %b expected 0100", bus.ack); end
        bus.req[2] = 1'b0;
        checks++; if (bus.grant_id !== 2'd2 || bus.tx_data !== 8'hA5) begin failures++; $display("FAIL single_grant: got id %0d data %h expected id 2 data a5", bus.grant_id, bus.tx_data); end
        ten = 0;
        while (bus.tx_en === 1'b1 && ten < 50) begin ten++; @(negedge clk); end
        checks++; if (ten != 4) begin failures++; $display("FAIL single_tx_en_len: got %0d expected 4", ten); end
        wait_done(400, seen);
        checks++; if (!seen || bus.done !== 4'b0100) begin failures++; $display("FAIL single_done: got %b expected 0100", bus.done); end
        checks++; if (bus.tx_data !== 8'hA5 || bus.busy !== 1'b0) begin failures++; $display("FAIL single_after: got data %h busy %b expected a5 0", bus.tx_data, bus.busy); end
        repeat (5) @(negedge clk);
        checks++; if (ack_cnt[2] - a0 != 1 || done_cnt[2] - d0 != 1) begin failures++; $display("FAIL single_counts: got ack %0d done %0d expected 1 1", ack_cnt[2] - a0, done_cnt[2] - d0); end
    endtask

    task automatic test_contention();
        int exp_id[5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp_data[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int a_snap[N];
        int r0, v0, id;
        bit seen, ok;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) a_snap[i] = ack_cnt[i];
        r0 = rise_total; v0 = viol;
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_ack(600, seen);
            id = -1;
            for (int i = 0; i < N; i++) if (bus.ack[i]) id = i;
            checks++; if (!seen || bus.ack !== (4'b0001 << exp_id[g])) begin failures++; $display("FAIL contention_order%0d: got %b expected id %0d", g, bus.ack, exp_id[g]); end
            checks++; if (bus.tx_data !== exp_data[exp_id[g]]) begin failures++; $display("FAIL contention_data%0d: got %h expected %h", g, bus.tx_data, exp_data[exp_id[g]]); end
            if (id >= 0) begin
                bus.req[id] = 1'b0;
                @(negedge clk);
                if (g < 4) bus.req[id] = 1'b1;
            end
        end
        bus.req = 4'b0000;
        wait_done(400, seen);
        repeat (3) @(negedge clk);
        ok = (ack_cnt[0] - a_snap[0] == 2) && (ack_cnt[1] - a_snap[1] == 1) &&
             (ack_cnt[2] - a_snap[2] == 1) && (ack_cnt[3] - a_snap[3] == 1);
        checks++; if (!ok) begin failures++; $display("FAIL contention_ack_counts: got %0d %0d %0d %0d expected 2 1 1 1", ack_cnt[0] - a_snap[0], ack_cnt[1] - a_snap[1], ack_cnt[2] - a_snap[2], ack_cnt[3] - a_snap[3]); end
        checks++; if (rise_total - r0 != 5 || viol != v0) begin failures++; $display("FAIL contention_tx_en: got rises %0d violations %0d expected 5 0", rise_total - r0, viol - v0); end
    endtask

    task automatic test_timeout();
        int d0;
        bit seen;
        d0 = done_total;
        snd_en = 1'b0;
        bus.req_data[15:8] = 8'h5A;
        bus.req[1] = 1'b1;
        wait_ack(20, seen);
        checks++; if (!seen || bus.ack !== 4'b0010) begin failures++; $display("FAIL timeout_ack: got %b expected 0010", bus.ack); end
        bus.req[1] = 1'b0;
        for (int n = 1; n <= 1028; n++) begin
            @(negedge clk);
            if (n == 1027) begin
                checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_early: got %b expected 0", bus.timeout_err); end
                bus.err_clr = 1'b1;
            end
        end
        checks++; if (bus.timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_set_wins: got %b expected 1", bus.timeout_err); end
        bus.err_clr = 1'b0;
        checks++; if (bus.busy !== 1'b0 || done_total != d0) begin failures++; $display("FAIL timeout_idle: got busy %b dones %0d expected 0 0", bus.busy, done_total - d0); end
        snd_en = 1'b1;
        bus.req_data[31:24] = 8'hC3;
        bus.req[3] = 1'b1;
        wait_ack(20, seen);
        checks++; if (!seen || bus.ack !== 4'b1000 || bus.tx_data !== 8'hC3) begin failures++; $display("FAIL timeout_next_ack: got %b data %h expected 1000 c3", bus.ack, bus.tx_data); end
        bus.req[3] = 1'b0;
        wait_done(400, seen);
        checks++; if (!seen || bus.done !== 4'b1000) begin failures++; $display("FAIL timeout_next_done: got %b expected 1000", bus.done); end
        checks++; if (bus.timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %b expected 1", bus.timeout_err); end
        @(negedge clk); bus.err_clr = 1'b1;
        @(negedge clk); bus.err_clr = 1'b0;
        checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL err_clr: got %b expected 0", bus.timeout_err); end
    endtask

    task automatic test_ext_busy();
        int a0, lat;
        bit seen;
        ext_busy = 1'b1;
        repeat (5) @(negedge clk);
        a0 = ack_total;
        bus.req_data[15:8] = 8'h77;
        bus.req[1] = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (ack_total != a0 || bus.busy !== 1'b0) begin failures++; $display("FAIL ext_busy_hold: got acks %0d busy %b expected 0 0", ack_total - a0, bus.busy); end
        ext_busy = 1'b0;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (|bus.ack) begin lat = n; break; end
        end
        checks++; if (lat != 3) begin failures++; $display("FAIL ext_busy_latency: got %0d expected 3", lat); end
        checks++; if (bus.ack !== 4'b0010 || bus.grant_id !== 2'd1 || bus.tx_data !== 8'h77) begin failures++; $display("FAIL ext_busy_grant: got %b id %0d data %h expected 0010 1 77", bus.ack, bus.grant_id, bus.tx_data); end
        bus.req[1] = 1'b0;
        wait_done(400, seen);
        checks++; if (!seen || bus.done !== 4'b0010) begin failures++; $display("FAIL ext_busy_done: got %b expected 0010", bus.done); end
    endtask

    task automatic test_reset_mid();
        int d0;
        bit seen;
        bus.req_data[7:0] = 8'h3C;
        bus.req[0] = 1'b1;
        wait_ack(20, seen);
        checks++; if (!seen || bus.ack !== 4'b0001) begin failures++; $display("FAIL reset_mid_ack: got %b expected 0001", bus.ack); end
        bus.req[0] = 1'b0;
        repeat (64) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL reset_mid_busy_before: got %b expected 1", bus.busy); end
        d0 = done_total;
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.tx_en !== 1'b0 || bus.busy !== 1'b0 || bus.grant_id !== GNT_W'(N-1) || bus.tx_data !== 8'h00) begin failures++; $display("FAIL reset_mid_async: got tx_en %b busy %b id %0d data %h expected 0 0 %0d 00", bus.tx_en, bus.busy, bus.grant_id, bus.tx_data, N-1); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        checks++; if (done_total != d0 || bus.busy !== 1'b0) begin failures++; $display("FAIL reset_mid_no_done: got dones %0d busy %b expected 0 0", done_total - d0, bus.busy); end
    endtask

`ifdef UART_TX_ARB_LOCK_EN
    task automatic test_lock();
        bit seen;
        bus.req_lock = 4'b0010;
        bus.req_data[15:8] = 8'hB1;
        bus.req[1] = 1'b1;
        wait_ack(20, seen);
        checks++; if (!seen || bus.ack !== 4'b0010) begin failures++; $display("FAIL lock_byte1: got %b expected 0010", bus.ack); end
        bus.req[1] = 1'b0;
        @(negedge clk);
        bus.req_data[15:8] = 8'hB2;
        bus.req_data[7:0]  = 8'h0A;
        bus.req[1] = 1'b1;
        bus.req[0] = 1'b1;
        wait_ack(600, seen);
        checks++; if (!seen || bus.ack !== 4'b0010 || bus.tx_data !== 8'hB2) begin failures++; $display("FAIL lock_byte2: got %b data %h expected 0010 b2", bus.ack, bus.tx_data); end
        bus.req[1] = 1'b0;
        @(negedge clk);
        bus.req_data[15:8] = 8'hB3;
        bus.req[1] = 1'b1;
        wait_ack(600, seen);
        checks++; if (!seen || bus.ack !== 4'b0010 || bus.tx_data !== 8'hB3) begin failures++; $display("FAIL lock_byte3: got %b data %h expected 0010 b3", bus.ack, bus.tx_data); end
        bus.req[1] = 1'b0;
        bus.req_lock = 4'b0000;
        wait_ack(600, seen);
        checks++; if (!seen || bus.ack !== 4'b0001 || bus.tx_data !== 8'h0A) begin failures++; $display("FAIL lock_release: got %b data %h expected 0001 0a", bus.ack, bus.tx_data); end
        bus.req[0] = 1'b0;
        wait_done(400, seen);
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) begin ack_cnt[i] = 0; done_cnt[i] = 0; end
        bus.req      = '0;
        bus.req_data = '0;
        bus.err_clr  = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
        bus.req_lock = '0;
`endif
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_ext_busy();
        test_reset_mid();
`ifdef UART_TX_ARB_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
